// File: rtl/multi_sampler_n.sv
// Base sampling strobe every P qualified ext_trig events, plus N_DS downsampled strobes gated onto it.
// Latency: sample_out and ds_stb are registered, asserted 1 clk after the qualifying tick.
// Backpressure: none; free-running strobe generator. ext_trig=0 freezes all state.
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   ext_trig        clock enable qualifying base counting
//   resync          single-cycle pulse; realigns base counter and all channels
//   sample_period   base period P in ext_trig events (0 and 1 both mean every event)
//   ds_period       channel k period D_k at [k*DS_WI +: DS_WI], in base ticks (0 = off)
//   ds_phase        channel k phase F_k applied on resync, in base ticks
//   ds_enable       per-channel enable
//   sample_out      base strobe, one cycle
//   ds_stb          channel strobes, one cycle, only ever coincident with sample_out
//
// Optional feature: define MULTI_SAMPLER_PHASE_EN to honour ds_phase on resync.
// Without it, resync makes every enabled channel strobe on the first tick after
// resync and ds_phase is left unconnected internally.

module multi_sampler_n #(
   parameter int N_DS  = 4,
   parameter int SP_WI = 8,
   parameter int DS_WI = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ext_trig,
   input  logic                    resync,
   input  logic [SP_WI-1:0]        sample_period,
   input  logic [N_DS*DS_WI-1:0]   ds_period,
   input  logic [N_DS*DS_WI-1:0]   ds_phase,
   input  logic [N_DS-1:0]         ds_enable,
   output logic                    sample_out,
   output logic [N_DS-1:0]         ds_stb
);

   logic [SP_WI-1:0] bc;
   logic [SP_WI-1:0] p_latched;
   logic             tick;
   logic             bc_wrap;
   logic             p_changed;

   // A tick is a qualified event landing on count zero; resync suppresses it.
   assign tick = ext_trig & ~resync & (bc == '0);

   // P<=1 short-circuits so the wrapped value of sample_period-1 is never used.
   assign bc_wrap = (sample_period <= SP_WI'(1)) || (bc >= (sample_period - SP_WI'(1)));

   // A new period restarts the count, but only if we are mid-count.
   assign p_changed = (sample_period != p_latched) && (bc != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bc         <= '0;
         p_latched  <= '0;
         sample_out <= 1'b0;
      end else begin
         sample_out <= tick;
         if (resync) begin
            bc        <= '0;
            p_latched <= sample_period;
         end else if (ext_trig) begin
            p_latched <= sample_period;
            if (p_changed || bc_wrap) begin
               bc <= '0;
            end else begin
               bc <= bc + SP_WI'(1);
            end
         end
      end
   end

`ifndef MULTI_SAMPLER_PHASE_EN
   logic phase_unused;
   assign phase_unused = ^ds_phase;
`endif

   for (genvar k = 0; k < N_DS; k++) begin : g_ch
      logic [DS_WI-1:0] d;
      logic [DS_WI-1:0] dc;
      logic [DS_WI-1:0] dc_load;
      logic             stb_q;

      assign d = ds_period[k*DS_WI +: DS_WI];

`ifdef MULTI_SAMPLER_PHASE_EN
      logic [DS_WI-1:0] f;
      assign f = ds_phase[k*DS_WI +: DS_WI];
      // dc counts down to 1 on ticks; loading F+1 places the first strobe on
      // tick index F. Phases at or beyond the period clamp to D-1. F+1 cannot
      // overflow because it is only taken when F < D.
      assign dc_load = (f >= d) ? d : (f + DS_WI'(1));
`else
      assign dc_load = DS_WI'(1);
`endif

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            dc    <= DS_WI'(1);
            stb_q <= 1'b0;
         end else begin
            stb_q <= 1'b0;
            if (resync) begin
               dc <= dc_load;
            end else if (tick) begin
               // Disabled or zero-period channels park at 1 so that re-enabling
               // strobes on the very next tick.
               if (!ds_enable[k] || (d == '0)) begin
                  dc <= DS_WI'(1);
               end else if (dc == DS_WI'(1)) begin
                  stb_q <= 1'b1;
                  dc    <= d;
               end else begin
                  dc <= dc - DS_WI'(1);
               end
            end
         end
      end

      assign ds_stb[k] = stb_q;
   end

endmodule
